tick_countdown: RTL and testbench
=================================

# tick_countdown

Programmable down-counter driven by the one-cycle-per-second enable pulse from the slow clock divider. Counts a loaded number of ticks, then flags expiry with a one-cycle `done` pulse and a sticky `expired` level. It sits directly downstream of the divider and feeds the display and alarm logic. All logic runs on the fast system clock; `tick` is used only as a clock enable.

## Interface
- `WIDTH`, 16, width of the count and load value (2..32)
- `clk`  input  1  system clock (24 MHz); all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `tick`  input  1  single-cycle enable pulse from the slow clock divider; one pulse = one count
- `load`  input  1  load strobe; samples `load_val`
- `load_val`  input  WIDTH  value to count down from
- `start`  input  1  start/resume strobe
- `stop`  input  1  pause strobe
- `count`  output  WIDTH  current remaining ticks (registered)
- `running`  output  1  high while in RUN (registered)
- `done`  output  1  one-cycle pulse on expiry (registered)
- `expired`  output  1  sticky expiry flag; cleared by `load` or reset

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. `running` = (state == RUN).
- Command priority in any cycle: `load` > `stop` > `start` > `tick`.
- `load` (any state): `count` <= `load_val`; state -> IDLE; `expired` <= 0; tick that cycle is ignored.
- `start` in IDLE or PAUSED with `count` != 0: -> RUN. With `count` == 0: ignored, stays put. Ignored in RUN and EXPIRED.
- `stop` in RUN: -> PAUSED, no decrement that cycle. Ignored elsewhere.
- `tick` in RUN with no higher-priority command:
  - `count` > 1: `count` <= `count` - 1.
  - `count` == 1: `count` <= 0; `done` <= 1 for one cycle; `expired` <= 1; -> EXPIRED.
- `tick` outside RUN: no effect. Ticks are never queued.
- A `start` coincident with `tick` enters RUN only; first decrement is on the next `tick`.
- EXPIRED holds `count` = 0 until `load`. `start` in EXPIRED is ignored.
- Arithmetic: unsigned modulo 2^WIDTH; `count` never underflows because RUN is never entered or held at 0.
- `load_val` = 0 loads 0; subsequent `start` is ignored.

## Timing
- Reset (async assert, sync release by the next edge): `count` = 0, state IDLE, `running` = 0, `done` = 0, `expired` = 0.
- Reset mid-run aborts immediately; no `done` is issued.
- All outputs registered; each change is visible one `clk` cycle after the sampling edge.
- `done` is high for exactly one `clk` cycle, in the cycle after the edge that samples the final `tick`. `expired` and `count` = 0 appear in the same cycle.
- Strobes are sampled every edge. Holding `start` high is equivalent to a single strobe.
- `tick` pulses are assumed to be at least 2 `clk` cycles apart. Back-to-back pulses each decrement.

## Configuration
- `TICK_COUNTDOWN_AUTO_RELOAD_EN` defined:
  - A WIDTH-bit reload register captures `load_val` on every `load`; reset value 0.
  - On expiry, `count` <= reload value and the state stays RUN. `done` still pulses; `expired` stays 0; `running` stays 1.
  - If the reload value is 0, the block behaves as the non-auto-reload case (-> EXPIRED).
- Undefined: no reload register; expiry always goes to EXPIRED as described above.

## Test plan
- Reset, `load_val`=3 + `load`, `start`, 3 ticks 8 cycles apart -> `count` 3,2,1,0. `done` high exactly 1 cycle after the 3rd tick. `expired`=1, `running`=0. A 4th tick leaves `count`=0.
- Load 5, start, 2 ticks, `stop`, 3 ticks, `start`, 3 ticks -> `count` holds 3 while PAUSED, then reaches 0 with a single `done`.
- Same-cycle conflicts: `stop`+`tick` in RUN at `count`=4 -> 4, PAUSED. `load`(9)+`tick` -> 9, IDLE. `start`+`tick` from IDLE at 2 -> 2, RUN.
- `load_val`=0, `start` -> stays IDLE, `running`=0, no `done`. `start` in EXPIRED -> no change.
- Assert `rst_n` low mid-run at `count`=7 -> all outputs 0 asynchronously, no `done`. After release, ticks have no effect.
- With `TICK_COUNTDOWN_AUTO_RELOAD_EN`: load 2, start, 6 ticks -> `count` 1,0→2 reload,1,2,1,2 pattern, with `done` pulses on the 2nd, 4th, and 6th ticks. `expired` stays 0 and `running` stays 1 throughout.

Source files
------------

// File: rtl/tick_countdown.sv
// tick_countdown: programmable down-counter clocked by clk, advanced by the
// one-per-second `tick` enable from the slow divider. Counts a loaded value
// down to zero, then emits a one-cycle `done` pulse and raises a sticky
// `expired` flag that is cleared only by `load` or reset.
//
// Optional feature: define TICK_COUNTDOWN_AUTO_RELOAD_EN to add a reload
// register. With a nonzero reload value, expiry reloads the counter and
// keeps running instead of entering EXPIRED.
//
// Command priority each cycle: load > stop > start > tick. The `start` and
// `stop` strobes only act in the states where they are meaningful; in RUN a
// held `start` is a no-op, so it never masks ticks.

module tick_countdown #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic             running_r;
    logic             done_r;
    logic             expired_r;

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_r;

    // Reload register: remembers the most recent load value for auto-reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_r <= CNT_ZERO;
        end else if (load) begin
            reload_r <= load_val;
        end else begin
            reload_r <= reload_r;
        end
    end
`endif

    // Control FSM with registered count and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-armed below
            done_r <= 1'b0;
            if (load) begin
                // load wins over everything; a coincident tick is dropped
                state_r   <= ST_IDLE;
                count_r   <= load_val;
                running_r <= 1'b0;
                expired_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_PAUSED: begin
                        // a coincident tick is not applied: first decrement
                        // happens on the next tick after entering RUN
                        if (start && (count_r != CNT_ZERO)) begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end else begin
                            running_r <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_r   <= ST_PAUSED;
                            running_r <= 1'b0;
                        end else if (tick) begin
                            if (count_r > CNT_ONE) begin
                                count_r   <= count_r - CNT_ONE;
                                running_r <= 1'b1;
                            end else if (count_r == CNT_ONE) begin
                                done_r <= 1'b1;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
                                if (reload_r != CNT_ZERO) begin
                                    count_r   <= reload_r;
                                    running_r <= 1'b1;
                                end else begin
                                    state_r   <= ST_EXPIRED;
                                    count_r   <= CNT_ZERO;
                                    running_r <= 1'b0;
                                    expired_r <= 1'b1;
                                end
`else
                                state_r   <= ST_EXPIRED;
                                count_r   <= CNT_ZERO;
                                running_r <= 1'b0;
                                expired_r <= 1'b1;
`endif
                            end else begin
                                // unreachable (RUN is never held at zero);
                                // park safely without a spurious done
                                state_r   <= ST_EXPIRED;
                                count_r   <= CNT_ZERO;
                                running_r <= 1'b0;
                                expired_r <= 1'b1;
                            end
                        end else begin
                            running_r <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        // hold zero until the next load; start is ignored
                        count_r   <= CNT_ZERO;
                        running_r <= 1'b0;
                        expired_r <= 1'b1;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        count_r   <= CNT_ZERO;
                        running_r <= 1'b0;
                        expired_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count   = count_r;
    assign running = running_r;
    assign done    = done_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_tick_countdown.sv
// Directed testbench for tick_countdown; expected values are hand-computed.
// Build with TICK_COUNTDOWN_AUTO_RELOAD_EN defined to exercise the reload
// sequence instead of the default expiry scenarios.

module tb_tick_countdown;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             expired;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int done_mark;

    tick_countdown #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    // Count every cycle in which done is seen high (sampled mid-cycle).
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load_val = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        // reset state (async, checked while held)
        #2;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_expired", expired, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
        // auto-reload: load 2, six ticks -> 1,2,1,2,1,2 with done on even ticks
        do_load(16'd2);
        do_start();
        for (int i = 1; i <= 6; i++) begin
            do_tick();
            check("ar_count", count, (i % 2 == 1) ? 32'd1 : 32'd2);
            check("ar_done", done, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("ar_running", running, 1);
            check("ar_expired", expired, 0);
            repeat (3) cyc();
        end
        check("ar_done_total", n_done, 3);
`else
        // basic countdown 3,2,1,0
        done_mark = n_done;
        do_load(16'd3);
        check("t1_load", count, 3);
        do_start();
        check("t1_running", running, 1);
        do_tick();
        check("t1_c2", count, 2);
        check("t1_nodone", done, 0);
        repeat (7) cyc();
        do_tick();
        check("t1_c1", count, 1);
        repeat (7) cyc();
        do_tick();
        check("t1_c0", count, 0);
        check("t1_done", done, 1);
        check("t1_expired", expired, 1);
        check("t1_stopped", running, 0);
        cyc();
        check("t1_done_1cyc", done, 0);
        repeat (6) cyc();
        do_tick();
        check("t1_c0_hold", count, 0);
        check("t1_done_total", n_done - done_mark, 1);

        // pause/resume
        done_mark = n_done;
        do_load(16'd5);
        check("t2_expired_clr", expired, 0);
        do_start();
        repeat (2) begin do_tick(); repeat (3) cyc(); end
        check("t2_c3", count, 3);
        do_stop();
        check("t2_paused", running, 0);
        repeat (3) begin do_tick(); repeat (3) cyc(); end
        check("t2_hold3", count, 3);
        do_start();
        check("t2_resume", running, 1);
        do_tick(); repeat (3) cyc();
        do_tick(); repeat (3) cyc();
        check("t2_c1", count, 1);
        do_tick();
        check("t2_c0", count, 0);
        check("t2_done", done, 1);
        repeat (3) cyc();
        check("t2_done_total", n_done - done_mark, 1);

        // same-cycle conflicts
        do_load(16'd5);
        do_start();
        do_tick();
        check("t3_c4", count, 4);
        stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0;
        check("t3_stop_tick_cnt", count, 4);
        check("t3_stop_tick_run", running, 0);
        load_val = 16'd9; load = 1'b1; tick = 1'b1; cyc(); load = 1'b0; tick = 1'b0;
        check("t3_load_tick_cnt", count, 9);
        check("t3_load_tick_run", running, 0);
        do_load(16'd2);
        start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0;
        check("t3_start_tick_cnt", count, 2);
        check("t3_start_tick_run", running, 1);

        // zero load, start ignored; start in EXPIRED ignored
        done_mark = n_done;
        do_load(16'd0);
        do_start();
        repeat (2) cyc();
        check("t4_zero_run", running, 0);
        check("t4_zero_cnt", count, 0);
        check("t4_zero_nodone", n_done - done_mark, 0);
        do_load(16'd1);
        do_start();
        do_tick();
        check("t4_exp", expired, 1);
        repeat (2) cyc();
        do_start();
        check("t4_exp_start_run", running, 0);
        check("t4_exp_start_cnt", count, 0);
        check("t4_exp_start_exp", expired, 1);

        // async reset mid-run
        do_load(16'd9);
        do_start();
        do_tick(); repeat (3) cyc();
        do_tick();
        check("t5_c7", count, 7);
        done_mark = n_done;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_cnt", count, 0);
        check("t5_rst_run", running, 0);
        check("t5_rst_exp", expired, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        do_tick(); repeat (3) cyc();
        do_tick();
        check("t5_post_cnt", count, 0);
        check("t5_post_run", running, 0);
        check("t5_nodone", n_done - done_mark, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
